// File: rtl/voice_frame_arbiter.sv
// Round-robin arbiter sharing one audio framing path between the
// left and right channel caches; emits vsync/href framing per frame.
module voice_frame_arbiter #(
  parameter int VSYNC_WIDTH = 32,
  parameter int GAP_WIDTH   = 16,
  parameter int HREF_WIDTH  = 1024,
  parameter int HREF_NUM    = 128
) (
  input  logic       sck,
  input  logic       rst,
  input  logic       enable,
  input  logic       req_l,
  input  logic       req_r,
  input  logic       empty_l,
  input  logic       empty_r,
  input  logic [7:0] data_l,
  input  logic [7:0] data_r,
  output logic       rd_en_l,
  output logic       rd_en_r,
  output logic       voice_vsync,
  output logic       voice_href,
  output logic [7:0] data_out,
  output logic       chan_id,
  output logic       frame_done,
  output logic       underrun
);

  localparam int CMAX = (HREF_WIDTH > VSYNC_WIDTH) ?
    ((HREF_WIDTH > GAP_WIDTH) ? HREF_WIDTH : GAP_WIDTH) :
    ((VSYNC_WIDTH > GAP_WIDTH) ? VSYNC_WIDTH : GAP_WIDTH);
  localparam int CW = $clog2(CMAX + 1);
  localparam int LW = $clog2(HREF_NUM + 1);

  localparam logic [CW-1:0] VS_LAST = CW'(VSYNC_WIDTH - 1);
  localparam logic [CW-1:0] GP_LAST = CW'(GAP_WIDTH - 1);
  localparam logic [CW-1:0] HR_LAST = CW'(HREF_WIDTH - 1);
  localparam logic [LW-1:0] LN_LAST = LW'(HREF_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_GAP,
    S_WAIT,
    S_LINE,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] line_cnt;
  logic          ptr;
  logic          ur_q;
  logic          in_line;
  logic          req_g;
  logic          pick;

  assign in_line = (state == S_LINE);
  assign rd_en_l = in_line & ~chan_id;
  assign rd_en_r = in_line & chan_id;
  assign req_g   = chan_id ? req_r : req_l;
  // Pointed-to channel wins if it requests, otherwise the other one.
  assign pick    = ptr ? req_r : ~req_l;

  assign underrun = ur_q | (rd_en_l & empty_l) | (rd_en_r & empty_r);
  assign data_out = !voice_href ? 8'h00 :
                    chan_id ? data_r : data_l;

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      line_cnt    <= '0;
      ptr         <= 1'b0;
      ur_q        <= 1'b0;
      chan_id     <= 1'b0;
      voice_vsync <= 1'b0;
      voice_href  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      voice_vsync <= (state == S_VSYNC);
      voice_href  <= in_line;
      frame_done  <= 1'b0;
      ur_q        <= underrun;
      cnt         <= cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (enable && (req_l || req_r)) begin
            state   <= S_VSYNC;
            chan_id <= pick;
          end
        end
        S_VSYNC: begin
          line_cnt <= '0;
          if (cnt == VS_LAST) begin
            state <= S_GAP;
            cnt   <= '0;
          end
        end
        S_GAP: begin
          if (cnt == GP_LAST) begin
            state <= S_WAIT;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          cnt <= '0;
          if (line_cnt == LN_LAST) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end else if (req_g) begin
            state <= S_LINE;
          end
        end
        S_LINE: begin
          if (cnt == HR_LAST) begin
            state    <= S_GAP;
            cnt      <= '0;
            line_cnt <= line_cnt + 1'b1;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          ptr   <= ~chan_id;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_frame_arbiter.sv
// Randomized bench for voice_frame_arbiter: FIFO responders, a trace
// monitor and a frame-level reference model.
module tb_voice_frame_arbiter;

  localparam int VW = 4;
  localparam int GW = 2;
  localparam int HW = 8;
  localparam int HN = 3;
  localparam int LINE_LEN = GW + 1 + HW;
  localparam int SPAN = VW + HN * LINE_LEN + GW;
  localparam int BUDGET = 300;

  logic       sck = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       req_l = 1'b0;
  logic       req_r = 1'b0;
  logic       empty_l = 1'b0;
  logic       empty_r = 1'b0;
  logic [7:0] data_l = 8'h00;
  logic [7:0] data_r = 8'h00;
  logic       rd_en_l, rd_en_r, voice_vsync, voice_href;
  logic [7:0] data_out;
  logic       chan_id, frame_done, underrun;

  voice_frame_arbiter #(
    .VSYNC_WIDTH(VW),
    .GAP_WIDTH  (GW),
    .HREF_WIDTH (HW),
    .HREF_NUM   (HN)
  ) dut (
    .sck        (sck),
    .rst        (rst),
    .enable     (enable),
    .req_l      (req_l),
    .req_r      (req_r),
    .empty_l    (empty_l),
    .empty_r    (empty_r),
    .data_l     (data_l),
    .data_r     (data_r),
    .rd_en_l    (rd_en_l),
    .rd_en_r    (rd_en_r),
    .voice_vsync(voice_vsync),
    .voice_href (voice_href),
    .data_out   (data_out),
    .chan_id    (chan_id),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 sck = ~sck;

  int checks = 0;
  int errors = 0;

  // FIFO responders: a read issued in one cycle shows data the next.
  logic       rd_l_s = 1'b0;
  logic       rd_r_s = 1'b0;
  logic [7:0] nb_l, nb_r;
  logic [7:0] exp_l[$];
  logic [7:0] exp_r[$];

  always @(negedge sck) begin
    rd_l_s = rd_en_l;
    rd_r_s = rd_en_r;
  end

  always @(posedge sck) begin
    if (rd_l_s) begin
      nb_l = 8'($urandom_range(0, 255));
      data_l = nb_l;
      exp_l.push_back(nb_l);
    end
    if (rd_r_s) begin
      nb_r = 8'($urandom_range(0, 255));
      data_r = nb_r;
      exp_r.push_back(nb_r);
    end
  end

  // Trace statistics gathered away from the active edge.
  int   cyc, vs_run, hr_run, gap_run, lines_f, vs_rise;
  int   n_rd_l, n_rd_r, n_done, n_bytes, data_bad;
  int   vs_runs[$];
  int   hr_runs[$];
  int   gap_runs[$];
  int   done_lens[$];
  logic chans[$];
  logic [7:0] want;

  always @(negedge sck) begin
    if (!rst) begin
      cyc++;
      if (voice_vsync) begin
        if (vs_run == 0) vs_rise = cyc;
        vs_run++;
        lines_f = 0;
        gap_run = 0;
      end else if (vs_run > 0) begin
        vs_runs.push_back(vs_run);
        vs_run = 0;
      end
      if (voice_href) begin
        if (lines_f > 0 && gap_run > 0) gap_runs.push_back(gap_run);
        gap_run = 0;
        hr_run++;
        n_bytes++;
        if (chan_id ? exp_r.size() == 0 : exp_l.size() == 0) begin
          data_bad++;
        end else begin
          want = chan_id ? exp_r.pop_front() : exp_l.pop_front();
          if (data_out !== want) data_bad++;
        end
      end else begin
        if (hr_run > 0) begin
          hr_runs.push_back(hr_run);
          hr_run = 0;
          lines_f++;
        end
        gap_run++;
        if (data_out !== 8'h00) data_bad++;
      end
      n_rd_l += int'(rd_en_l);
      n_rd_r += int'(rd_en_r);
      if (frame_done) begin
        n_done++;
        chans.push_back(chan_id);
        done_lens.push_back(cyc - vs_rise);
      end
    end
  end

  task automatic clear_stats();
    cyc = 0; vs_run = 0; hr_run = 0; gap_run = 0; lines_f = 0;
    vs_rise = 0; n_rd_l = 0; n_rd_r = 0; n_done = 0;
    n_bytes = 0; data_bad = 0;
    vs_runs.delete(); hr_runs.delete(); gap_runs.delete();
    done_lens.delete(); chans.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sck);
      #1;
    end
  endtask

  task automatic wait_done(input int target, output int got);
    int k = 0;
    while (n_done < target && k < BUDGET * target) begin
      tick(1);
      k++;
    end
    got = n_done;
  endtask

  // Reference pointer: pointed-to channel if it requests, else the other.
  logic mptr = 1'b0;

  function automatic logic grant_of(input logic p, input logic rl,
                                    input logic rr);
    logic wants;
    wants = p ? rr : rl;
    return wants ? p : ~p;
  endfunction

  task automatic test_reset();
    tick(2);
    checks++;
    if ({rd_en_l, rd_en_r, voice_vsync, voice_href, data_out,
         chan_id, frame_done, underrun} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0",
               {rd_en_l, rd_en_r, voice_vsync, voice_href, data_out,
                chan_id, frame_done, underrun});
    end
    rst = 1'b0;
    clear_stats();
    enable = 1'b1;
    tick(12);
    checks++;
    if (vs_runs.size() + vs_run + n_rd_l + n_rd_r !== 0) begin
      errors++;
      $display("FAIL idle_no_req got vsync/rd activity %0d exp 0",
               vs_runs.size() + vs_run + n_rd_l + n_rd_r);
    end
  endtask

  task automatic test_single_left();
    int got;
    logic g;
    clear_stats();
    g = grant_of(mptr, 1'b1, 1'b0);
    req_l = 1'b1;
    wait_done(1, got);
    req_l = 1'b0;
    mptr = ~g;
    tick(6);
    checks++;
    if (got !== 1 || n_done !== 1) begin
      errors++;
      $display("FAIL single_done got %0d exp 1", n_done);
    end
    checks++;
    if (vs_runs.size() !== 1 || vs_runs[0] !== VW) begin
      errors++;
      $display("FAIL single_vsync got %0d runs exp 1 of %0d",
               vs_runs.size(), VW);
    end
    checks++;
    if (hr_runs.size() !== HN) begin
      errors++;
      $display("FAIL single_lines got %0d exp %0d", hr_runs.size(), HN);
    end
    foreach (hr_runs[i]) begin
      checks++;
      if (hr_runs[i] !== HW) begin
        errors++;
        $display("FAIL single_href_len line %0d got %0d exp %0d",
                 i, hr_runs[i], HW);
      end
    end
    foreach (gap_runs[i]) begin
      checks++;
      if (gap_runs[i] !== GW + 1) begin
        errors++;
        $display("FAIL single_gap line %0d got %0d exp %0d",
                 i, gap_runs[i], GW + 1);
      end
    end
    checks++;
    if (n_rd_l !== HN * HW || n_rd_r !== 0) begin
      errors++;
      $display("FAIL single_rd got l=%0d r=%0d exp l=%0d r=0",
               n_rd_l, n_rd_r, HN * HW);
    end
    checks++;
    if (chans.size() !== 1 || chans[0] !== g) begin
      errors++;
      $display("FAIL single_chan got %0d exp %0d", chan_id, g);
    end
    checks++;
    if (data_bad !== 0 || n_bytes !== HN * HW) begin
      errors++;
      $display("FAIL single_data got bad=%0d bytes=%0d exp 0/%0d",
               data_bad, n_bytes, HN * HW);
    end
    checks++;
    if (done_lens.size() !== 1 || done_lens[0] !== SPAN) begin
      errors++;
      $display("FAIL single_frame_len got %0d exp %0d",
               done_lens.size() > 0 ? done_lens[0] : -1, SPAN);
    end
  endtask

  task automatic test_round_robin();
    int got;
    logic exp_ch[$];
    logic g;
    int nl, nr;
    clear_stats();
    nl = 0;
    nr = 0;
    for (int f = 0; f < 3; f++) begin
      g = grant_of(mptr, 1'b1, 1'b1);
      exp_ch.push_back(g);
      if (g) nr++; else nl++;
      mptr = ~g;
    end
    req_l = 1'b1;
    req_r = 1'b1;
    wait_done(3, got);
    req_l = 1'b0;
    req_r = 1'b0;
    tick(6);
    checks++;
    if (got !== 3 || n_done !== 3) begin
      errors++;
      $display("FAIL rr_done got %0d exp 3", n_done);
    end
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (f >= chans.size() || chans[f] !== exp_ch[f]) begin
        errors++;
        $display("FAIL rr_chan frame %0d got %0d exp %0d", f,
                 f < chans.size() ? int'(chans[f]) : -1, exp_ch[f]);
      end
    end
    checks++;
    if (n_rd_l !== nl * HN * HW || n_rd_r !== nr * HN * HW) begin
      errors++;
      $display("FAIL rr_rd got l=%0d r=%0d exp l=%0d r=%0d",
               n_rd_l, n_rd_r, nl * HN * HW, nr * HN * HW);
    end
    checks++;
    if (data_bad !== 0 || hr_runs.size() !== 3 * HN) begin
      errors++;
      $display("FAIL rr_data got bad=%0d lines=%0d exp 0/%0d",
               data_bad, hr_runs.size(), 3 * HN);
    end
  endtask

  task automatic test_req_drop();
    int got, k, busy;
    logic g;
    clear_stats();
    g = grant_of(mptr, 1'b1, 1'b0);
    req_l = 1'b1;
    k = 0;
    while (hr_runs.size() < 1 && k < BUDGET) begin
      tick(1);
      k++;
    end
    checks++;
    if (hr_runs.size() !== 1) begin
      errors++;
      $display("FAIL drop_line1 got %0d lines exp 1", hr_runs.size());
    end
    req_l = 1'b0;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      busy += int'(rd_en_l | rd_en_r | voice_href | voice_vsync);
    end
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL drop_hold got %0d active cycles exp 0", busy);
    end
    req_l = 1'b1;
    wait_done(1, got);
    req_l = 1'b0;
    mptr = ~g;
    tick(6);
    checks++;
    if (got !== 1 || hr_runs.size() !== HN || n_rd_l !== HN * HW) begin
      errors++;
      $display("FAIL drop_frame got done=%0d lines=%0d rd=%0d exp 1/%0d/%0d",
               got, hr_runs.size(), n_rd_l, HN, HN * HW);
    end
    checks++;
    if (gap_runs.size() < 1 || gap_runs[0] < 20) begin
      errors++;
      $display("FAIL drop_gap got %0d exp >=20",
               gap_runs.size() > 0 ? gap_runs[0] : -1);
    end
    checks++;
    if (data_bad !== 0 || chans.size() !== 1 || chans[0] !== g) begin
      errors++;
      $display("FAIL drop_data got bad=%0d chan=%0d exp 0/%0d",
               data_bad, chan_id, g);
    end
  endtask

  task automatic test_underrun();
    int got, k;
    logic g;
    clear_stats();
    g = grant_of(mptr, 1'b1, 1'b0);
    req_l = 1'b1;
    k = 0;
    while (!rd_en_l && k < BUDGET) begin
      tick(1);
      k++;
    end
    tick(2);
    checks++;
    if (underrun !== 1'b0 || rd_en_l !== 1'b1) begin
      errors++;
      $display("FAIL ur_pre got ur=%0d rd=%0d exp 0/1", underrun, rd_en_l);
    end
    empty_l = 1'b1;
    #1;
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL ur_rise got %0d exp 1", underrun);
    end
    tick(1);
    empty_l = 1'b0;
    wait_done(1, got);
    req_l = 1'b0;
    mptr = ~g;
    tick(6);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL ur_sticky got %0d exp 1", underrun);
    end
    checks++;
    if (got !== 1 || done_lens.size() !== 1 || done_lens[0] !== SPAN ||
        n_rd_l !== HN * HW) begin
      errors++;
      $display("FAIL ur_timing got done=%0d rd=%0d exp 1 span %0d rd %0d",
               got, n_rd_l, SPAN, HN * HW);
    end
    checks++;
    if (chans.size() !== 1 || chans[0] !== g) begin
      errors++;
      $display("FAIL ur_chan got %0d exp %0d", chan_id, g);
    end
  endtask

  task automatic test_reset_midframe();
    int got, k;
    logic g;
    clear_stats();
    g = grant_of(mptr, 1'b1, 1'b1);
    req_l = 1'b1;
    req_r = 1'b1;
    k = 0;
    while (!(rd_en_l | rd_en_r) && k < BUDGET) begin
      tick(1);
      k++;
    end
    tick(4);
    checks++;
    if ((g ? rd_en_r : rd_en_l) !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_line got rd=%0d exp 1", g ? rd_en_r : rd_en_l);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_en_l, rd_en_r, voice_vsync, voice_href, data_out,
         chan_id, frame_done, underrun} !== 15'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got %b exp 0",
               {rd_en_l, rd_en_r, voice_vsync, voice_href, data_out,
                chan_id, frame_done, underrun});
    end
    tick(2);
    exp_l.delete();
    exp_r.delete();
    clear_stats();
    mptr = 1'b0;
    rst = 1'b0;
    g = grant_of(mptr, 1'b1, 1'b1);
    wait_done(1, got);
    req_l = 1'b0;
    req_r = 1'b0;
    mptr = ~g;
    tick(6);
    checks++;
    if (got !== 1 || chans.size() !== 1 || chans[0] !== g) begin
      errors++;
      $display("FAIL rstmid_restart got done=%0d chan=%0d exp 1/%0d",
               got, chan_id, g);
    end
    checks++;
    if (data_bad !== 0 || n_rd_l + n_rd_r !== HN * HW ||
        done_lens.size() !== 1 || done_lens[0] !== SPAN) begin
      errors++;
      $display("FAIL rstmid_frame got bad=%0d rd=%0d exp 0/%0d",
               data_bad, n_rd_l + n_rd_r, HN * HW);
    end
  endtask

  task automatic test_enable_drop();
    int got, k;
    logic g;
    clear_stats();
    g = grant_of(mptr, 1'b1, 1'b0);
    req_l = 1'b1;
    k = 0;
    while (hr_runs.size() < 1 && k < BUDGET) begin
      tick(1);
      k++;
    end
    enable = 1'b0;
    wait_done(1, got);
    mptr = ~g;
    checks++;
    if (got !== 1 || hr_runs.size() !== HN || chans.size() !== 1 ||
        chans[0] !== g) begin
      errors++;
      $display("FAIL en_complete got done=%0d lines=%0d exp 1/%0d",
               got, hr_runs.size(), HN);
    end
    tick(40);
    checks++;
    if (vs_runs.size() !== 1 || vs_run !== 0 || n_done !== 1) begin
      errors++;
      $display("FAIL en_idle got vsync runs=%0d exp 1", vs_runs.size());
    end
    enable = 1'b1;
    k = 0;
    while (!voice_vsync && k < BUDGET) begin
      tick(1);
      k++;
    end
    checks++;
    if (voice_vsync !== 1'b1 || chan_id !== grant_of(mptr, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL en_resume got vsync=%0d chan=%0d exp 1/%0d",
               voice_vsync, chan_id, grant_of(mptr, 1'b1, 1'b0));
    end
    req_l = 1'b0;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_single_left();
    test_round_robin();
    test_req_drop();
    test_underrun();
    test_reset_midframe();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
